// File: rtl/seq_cmd_port.sv
// seq_cmd_port: device-side receiver for the sequencer command bus.
// Captures {cmd, arg} words on this slot's write strobe, queues them in a
// small FIFO for the device core (valid/ready), and exposes a status byte
// {full, empty, overflow, count} that sequencer programs can poll.
// cmd 4'hF is a local FLUSH: it empties the queue and clears overflow.
module seq_cmd_port #(
    parameter int DepthLog2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [3:0]  cmd,
    output logic [7:0]  arg,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  stat
);

    localparam int DEPTH = 1 << DepthLog2;
    localparam int CW    = DepthLog2 + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [3:0]    CMD_FLUSH = 4'hF;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [11:0]          mem [DEPTH];
    logic [DepthLog2-1:0] rd_ptr;
    logic [DepthLog2-1:0] wr_ptr;
    logic [CW-1:0]        count;
    logic                 overflow;

    logic is_ready;
    logic is_flush;
    logic wr_req;
    logic pop;
    logic push;
    logic drop;
    logic is_full;
    logic is_empty;

    assign is_full  = (count == FULL_CNT);
    assign is_empty = (count == '0);

    // Strobe decode: FLUSH is handled locally; a full queue still accepts a
    // word when the head is being popped in the same cycle.
    assign is_flush = is_ready && inst_en && (inst[11:8] == CMD_FLUSH);
    assign wr_req   = is_ready && inst_en && (inst[11:8] != CMD_FLUSH);
    assign pop      = cmd_valid && cmd_ready;
    assign push     = wr_req && (!is_full || pop);
    assign drop     = wr_req && is_full && !pop;

    // State register; any edge with reset high returns to ST_RESET.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; an unknown encoding parks in ST_ERROR.
    always_comb begin
        state_next = state;
        is_ready   = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = 4'h0;
        arg        = 8'h00;
        stat       = {is_full, is_empty, overflow, 5'(count)};
        case (state)
            ST_RESET: begin
                state_next = ST_READY;
                stat       = 8'h40;
            end
            ST_READY: begin
                is_ready  = 1'b1;
                cmd_valid = !is_empty;
                if (!is_empty) begin
                    cmd = mem[rd_ptr][11:8];
                    arg = mem[rd_ptr][7:0];
                end
            end
            ST_ERROR: begin
                stat = 8'h60;
            end
            default: begin
                state_next = ST_ERROR;
                stat       = 8'h60;
            end
        endcase
    end

    // Queue bookkeeping: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset || is_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful under count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= inst;
        end
    end

endmodule

// File: tb/tb_seq_cmd_port.sv
// tb_seq_cmd_port: directed bench for seq_cmd_port (DepthLog2 = 2).
// A queue-based reference model tracks the expected FIFO contents and is
// compared against every DUT output on each falling edge; literal checks at
// key points pin the model to hand-computed values.
module tb_seq_cmd_port;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic        clock;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic [3:0]  cmd;
    logic [7:0]  arg;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  stat;

    int n_cmp;
    int n_bad;

    seq_cmd_port #(.DepthLog2(DL2)) dut (
        .clock     (clock),
        .reset     (reset),
        .inst      (inst),
        .inst_en   (inst_en),
        .cmd       (cmd),
        .arg       (arg),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .stat      (stat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the queue of words the device has yet to consume.
    logic [11:0] mq[$];
    bit          m_ovf;
    bit          m_live;     // past the first post-reset edge
    bit          m_started;  // seen at least one reset edge

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_live    = 1'b0;
            m_started = 1'b1;
        end else if (!m_live) begin
            m_live = 1'b1;
        end else begin
            bit do_pop;
            do_pop = (mq.size() != 0) && cmd_ready;
            if (inst_en && inst[11:8] == 4'hF) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (inst_en) begin
                    if (mq.size() < DEPTH) mq.push_back(inst);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] model_stat();
        int n;
        n = mq.size();
        return {(n == DEPTH), (n == 0), m_ovf, 5'(n)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (m_started) begin
            logic [11:0] head;
            head = (mq.size() != 0) ? mq[0] : 12'h000;
            check("model_valid", {31'd0, cmd_valid}, {31'd0, mq.size() != 0});
            check("model_cmd",   {28'd0, cmd}, {28'd0, head[11:8]});
            check("model_arg",   {24'd0, arg}, {24'd0, head[7:0]});
            check("model_stat",  {24'd0, stat}, {24'd0, model_stat()});
        end
    end

    // Advance one clock; inputs change 1 time unit after the active edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [11:0] w);
        inst    = w;
        inst_en = 1'b1;
        cyc();
        inst_en = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        inst      = 12'h000;
        inst_en   = 1'b0;
        cmd_ready = 1'b0;
        #1;
        cyc();
        cyc();
        check("rst_stat",  {24'd0, stat}, 32'h40);
        check("rst_valid", {31'd0, cmd_valid}, 32'h0);
        check("rst_cmd",   {28'd0, cmd}, 32'h0);

        // First edge out of reset: strobe must be ignored.
        reset   = 1'b0;
        inst    = 12'h123;
        inst_en = 1'b1;
        cyc();
        inst_en = 1'b0;
        check("ignore_in_reset", {24'd0, stat}, 32'h40);
        cyc();
        cyc();
        check("idle_stat", {24'd0, stat}, 32'h40);

        // Single word, visible the cycle after the strobe.
        write(12'h1A5);
        check("one_cmd",   {28'd0, cmd}, 32'h1);
        check("one_arg",   {24'd0, arg}, 32'hA5);
        check("one_valid", {31'd0, cmd_valid}, 32'h1);
        check("one_stat",  {24'd0, stat}, 32'h01);
        pop_one();
        check("one_popped", {24'd0, stat}, 32'h40);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) write(12'(i * 12'h101));
        check("full_stat", {24'd0, stat}, 32'h84);
        write(12'h505);
        check("ovf_stat", {24'd0, stat}, 32'hA4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_arg", {24'd0, arg}, 32'(i));
            pop_one();
        end
        check("drained_stat", {24'd0, stat}, 32'h60);

        // Flush clears overflow; full queue accepts push with concurrent pop.
        write(12'hF00);
        check("flush_stat", {24'd0, stat}, 32'h40);
        for (int i = 1; i <= 4; i++) write(12'(i * 12'h101));
        cmd_ready = 1'b1;
        write(12'h606);
        cmd_ready = 1'b0;
        check("pushpop_stat", {24'd0, stat}, 32'h84);
        check("pushpop_head", {24'd0, arg}, 32'h02);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_args [4];
            exp_args = '{8'h02, 8'h03, 8'h04, 8'h06};
            check("pushpop_order", {24'd0, arg}, {24'd0, exp_args[i]});
            pop_one();
        end
        check("pushpop_empty", {24'd0, stat}, 32'h40);

        // Two entries with overflow set, then FLUSH together with a pop.
        for (int i = 1; i <= 5; i++) write(12'(i * 12'h101));
        pop_one();
        pop_one();
        check("two_ovf_stat", {24'd0, stat}, 32'h22);
        cmd_ready = 1'b1;
        write(12'hF00);
        check("flushpop_stat",  {24'd0, stat}, 32'h40);
        check("flushpop_valid", {31'd0, cmd_valid}, 32'h0);
        cyc();
        cmd_ready = 1'b0;
        check("flushpop_after", {24'd0, stat}, 32'h40);

        // Streaming one-in one-out across several pointer wraps.
        cmd_ready = 1'b1;
        inst_en   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst = {4'(i % 8), 8'(8'h30 + i)};
            cyc();
            check("wrap_count", {24'd0, stat}, 32'h01);
            check("wrap_arg",   {24'd0, arg}, 32'(8'h30 + i));
        end
        inst_en = 1'b0;
        cyc();
        cmd_ready = 1'b0;
        check("wrap_done", {24'd0, stat}, 32'h40);

        // Reset mid-stream discards buffered words.
        write(12'h2AA);
        write(12'h3BB);
        check("pre_reset", {24'd0, stat}, 32'h02);
        reset   = 1'b1;
        inst    = 12'h4CC;
        inst_en = 1'b1;
        cyc();
        inst_en = 1'b0;
        check("mid_reset_stat",  {24'd0, stat}, 32'h40);
        check("mid_reset_valid", {31'd0, cmd_valid}, 32'h0);
        reset = 1'b0;
        cyc();
        cyc();
        check("post_reset", {24'd0, stat}, 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
